// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and instruction field layout for the pipeline hazard controller.
package pipeline_hazard_controller_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } state_e;

  // Low bit of each instruction field: op[31:28] rd[27:22] rs[21:16] rt[15:10]
  localparam int unsigned OpLsb = 28;
  localparam int unsigned RdLsb = 22;
  localparam int unsigned RsLsb = 16;
  localparam int unsigned RtLsb = 10;

  localparam logic [3:0] HaltOpDefault = 4'b1111;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Bundle of the controller's stimulus inputs and control/status outputs.
interface pipeline_hazard_controller_if #(
  parameter int unsigned CNT_W = 16
);

  logic             start;
  logic [31:0]      idInstr;
  logic             idRegWrite;
  logic             idUsesRs;
  logic             idUsesRt;
  logic             wbRedirect;

  logic             pcWrite;
  logic             ifidWrite;
  logic             ifidFlush;
  logic             idexFlush;
  logic             exwbFlush;
  logic             running;
  logic             halted;
  logic [CNT_W-1:0] cycleCount;
  logic [CNT_W-1:0] stallCount;
  logic [CNT_W-1:0] flushCount;

  modport master (
    output start, idInstr, idRegWrite, idUsesRs, idUsesRt, wbRedirect,
    input  pcWrite, ifidWrite, ifidFlush, idexFlush, exwbFlush, running, halted,
    input  cycleCount, stallCount, flushCount
  );

  modport slave (
    input  start, idInstr, idRegWrite, idUsesRs, idUsesRt, wbRedirect,
    output pcWrite, ifidWrite, ifidFlush, idexFlush, exwbFlush, running, halted,
    output cycleCount, stallCount, flushCount
  );

endinterface

// File: rtl/pipeline_hazard_controller_hazard_shadow_stage.sv
// One shadow slot (valid/rd/regwrite/halt) mirroring a pipeline buffer.
module hazard_shadow_stage #(
  parameter int unsigned REG_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             hold,
  input  logic             flush,
  input  logic             load_valid,
  input  logic [REG_W-1:0] load_rd,
  input  logic             load_regwrite,
  input  logic             load_halt,
  output logic             valid,
  output logic [REG_W-1:0] rd,
  output logic             regwrite,
  output logic             halt
);

  logic             valid_q;
  logic [REG_W-1:0] rd_q;
  logic             regwrite_q;
  logic             halt_q;

  // Flush wins over hold so a bubble always lands even in a held buffer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q    <= 1'b0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      halt_q     <= 1'b0;
    end else if (flush) begin
      valid_q    <= 1'b0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      halt_q     <= 1'b0;
    end else if (!hold) begin
      valid_q    <= load_valid;
      rd_q       <= load_rd;
      regwrite_q <= load_regwrite;
      halt_q     <= load_halt;
    end
  end

  assign valid    = valid_q;
  assign rd       = rd_q;
  assign regwrite = regwrite_q;
  assign halt     = halt_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Run/halt sequencer, RAW-hazard stall and WB-redirect squash control for a 4-stage pipeline.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int unsigned     REG_W     = 6,
  parameter int unsigned     OP_W      = 4,
  parameter logic [OP_W-1:0] HALT_OP   = OP_W'(HaltOpDefault),
  parameter bit              WB_BYPASS = 1'b1,
  parameter int unsigned     CNT_W     = 16
) (
  input logic                         clock,
  input logic                         reset_n,
  pipeline_hazard_controller_if.slave bus
);

  state_e state_q, state_d;

  logic             id_valid_q;
  logic [REG_W-1:0] id_rs, id_rt, id_rd;
  logic [OP_W-1:0]  id_op;

  logic             ex_valid, ex_regwrite, ex_halt;
  logic [REG_W-1:0] ex_rd;
  logic             wb_valid, wb_regwrite, wb_halt;
  logic [REG_W-1:0] wb_rd;

  logic             pc_write, ifid_write, ifid_flush, idex_flush, exwb_flush;
  logic             cycle_inc, stall_inc, flush_inc;
  logic [CNT_W-1:0] cycle_q, stall_q, flush_q;

  logic             rs_hit, rt_hit, hazard, eff_redirect;
  logic             unused_instr;

  assign id_op = bus.idInstr[OpLsb +: OP_W];
  assign id_rd = bus.idInstr[RdLsb +: REG_W];
  assign id_rs = bus.idInstr[RsLsb +: REG_W];
  assign id_rt = bus.idInstr[RtLsb +: REG_W];
  assign unused_instr = ^bus.idInstr[RtLsb-1:0];

  // With a write-before-read register file the WB producer is already visible to ID.
  assign rs_hit = (ex_valid & ex_regwrite & (ex_rd == id_rs)) |
                  (!WB_BYPASS & wb_valid & wb_regwrite & (wb_rd == id_rs));
  assign rt_hit = (ex_valid & ex_regwrite & (ex_rd == id_rt)) |
                  (!WB_BYPASS & wb_valid & wb_regwrite & (wb_rd == id_rt));

  assign hazard       = id_valid_q & ((bus.idUsesRs & rs_hit) | (bus.idUsesRt & rt_hit));
  assign eff_redirect = bus.wbRedirect & wb_valid;

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b1;
    idex_flush = 1'b1;
    exwb_flush = 1'b1;
    cycle_inc  = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = StRun;
      end
      StRun: begin
        cycle_inc = 1'b1;
        if (eff_redirect) begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          flush_inc  = 1'b1;
        end else if (hazard) begin
          ifid_flush = 1'b0;
          exwb_flush = 1'b0;
          stall_inc  = 1'b1;
        end else begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          ifid_flush = 1'b0;
          idex_flush = 1'b0;
          exwb_flush = 1'b0;
        end
        // A squashing redirect outranks a halt sitting in WB.
        if (wb_valid && wb_halt && !eff_redirect) state_d = StHalt;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (&value) ? value : value + CNT_W'(1);
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      id_valid_q <= 1'b0;
      cycle_q    <= '0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q <= state_d;
      if (ifid_flush) begin
        id_valid_q <= 1'b0;
      end else if (ifid_write) begin
        id_valid_q <= 1'b1;
      end
      if (cycle_inc) cycle_q <= sat_inc(cycle_q);
      if (stall_inc) stall_q <= sat_inc(stall_q);
      if (flush_inc) flush_q <= sat_inc(flush_q);
    end
  end

  hazard_shadow_stage #(
    .REG_W(REG_W)
  ) u_ex_slot (
    .clock        (clock),
    .reset_n      (reset_n),
    .hold         (1'b0),
    .flush        (idex_flush),
    .load_valid   (id_valid_q),
    .load_rd      (id_rd),
    .load_regwrite(bus.idRegWrite),
    .load_halt    (id_op == HALT_OP),
    .valid        (ex_valid),
    .rd           (ex_rd),
    .regwrite     (ex_regwrite),
    .halt         (ex_halt)
  );

  hazard_shadow_stage #(
    .REG_W(REG_W)
  ) u_wb_slot (
    .clock        (clock),
    .reset_n      (reset_n),
    .hold         (1'b0),
    .flush        (exwb_flush),
    .load_valid   (ex_valid),
    .load_rd      (ex_rd),
    .load_regwrite(ex_regwrite),
    .load_halt    (ex_halt),
    .valid        (wb_valid),
    .rd           (wb_rd),
    .regwrite     (wb_regwrite),
    .halt         (wb_halt)
  );

  assign bus.pcWrite    = pc_write;
  assign bus.ifidWrite  = ifid_write;
  assign bus.ifidFlush  = ifid_flush;
  assign bus.idexFlush  = idex_flush;
  assign bus.exwbFlush  = exwb_flush;
  assign bus.running    = (state_q == StRun);
  assign bus.halted     = (state_q == StHalt);
  assign bus.cycleCount = cycle_q;
  assign bus.stallCount = stall_q;
  assign bus.flushCount = flush_q;

endmodule
